// File: rtl/shot_responder_pkg.sv
// Shared types for the defender shot responder.
// Cell and message encodings, FSM states, board range helper.
package shot_responder_pkg;

  typedef enum logic [1:0] {
    EMPTY = 2'b00,
    SHIP  = 2'b01,
    HIT   = 2'b10,
    MISS  = 2'b11
  } cell_t;

  typedef enum logic [1:0] {
    MSG_NONE     = 2'b00,
    MSG_MISS     = 2'b01,
    MSG_HIT      = 2'b10,
    MSG_HIT_LAST = 2'b11
  } msg_t;

  typedef enum logic [1:0] {
    S_IDLE,
    S_LOOKUP,
    S_UPDATE,
    S_RESPOND
  } rsp_state_t;

  function automatic logic in_range(
    input logic [7:0] addr,
    input int         w,
    input int         h
  );
    return (int'(addr[3:0]) < w) &&
           (int'(addr[7:4]) < h);
  endfunction

endpackage

// File: rtl/shot_responder_if.sv
// Shot request / result message link.
// The link side is master, the responder is slave.
interface shot_responder_if;
  logic       shot_valid;
  logic [7:0] shot_addr;
  logic       shot_ready;
  logic       resp_valid;
  logic [1:0] resp_msg;
  logic       resp_ready;

  modport master (
    output shot_valid, shot_addr, resp_ready,
    input  shot_ready, resp_valid, resp_msg
  );

  modport slave (
    input  shot_valid, shot_addr, resp_ready,
    output shot_ready, resp_valid, resp_msg
  );
endinterface

// File: rtl/shot_responder_board_mem.sv
// 256 x 2-bit ship board: one write port, a registered FSM
// read, a registered display read and a placement probe.
module shot_responder_board_mem
  import shot_responder_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       clear,
  input  logic       we,
  input  logic [7:0] wr_addr,
  input  cell_t      wr_data,
  input  logic [7:0] fsm_addr,
  output cell_t      fsm_cell,
  input  logic [7:0] probe_addr,
  output cell_t      probe_cell,
  input  logic [7:0] disp_addr,
  input  logic       disp_ok,
  output cell_t      disp_cell
);

  logic [255:0][1:0] cells;

  // placement needs the current cell in the same cycle
  assign probe_cell = cell_t'(cells[probe_addr]);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cells     <= '0;
      fsm_cell  <= EMPTY;
      disp_cell <= EMPTY;
    end else if (clear) begin
      cells     <= '0;
      fsm_cell  <= EMPTY;
      disp_cell <= EMPTY;
    end else begin
      if (we)
        cells[wr_addr] <= wr_data;
      fsm_cell  <= cell_t'(cells[fsm_addr]);
      disp_cell <= disp_ok ?
                   cell_t'(cells[disp_addr]) :
                   EMPTY;
    end
  end

endmodule

// File: rtl/shot_responder.sv
// Defender side of the shot exchange: board lookup,
// cell marking, result messages and ship accounting.
module shot_responder
  import shot_responder_pkg::*;
#(
  parameter int BOARD_W   = 10,
  parameter int BOARD_H   = 10,
  parameter int MAX_CELLS = 11
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clear,
  input  logic             place_valid,
  input  logic [7:0]       place_addr,
  shot_responder_if.slave  sh,
  output logic [3:0]       ships_left,
  output logic             all_sunk,
  input  logic [7:0]       rd_addr,
  output logic [1:0]       rd_cell
);

  localparam logic [3:0] MAX_L = 4'(MAX_CELLS);

  rsp_state_t state;
  logic [7:0] addr_q;
  logic [3:0] left;
  logic       locked;
  logic       rdy;
  logic       rv;
  msg_t       msg;

  cell_t      fsm_cell;
  cell_t      probe_cell;
  cell_t      disp_cell;
  logic       we;
  logic [7:0] wr_addr;
  cell_t      wr_data;

  logic shot_fire;
  logic place_ok;
  logic shot_in;
  logic hit;
  logic we_shot;
  logic sunk;

  assign sunk      = locked && (left == 4'd0);
  assign shot_fire = (state == S_IDLE) && rdy &&
                     sh.shot_valid;
  assign place_ok  = (state == S_IDLE) && !shot_fire &&
                     place_valid && !locked &&
                     in_range(place_addr, BOARD_W, BOARD_H) &&
                     (probe_cell == EMPTY) &&
                     (left != MAX_L);

  assign shot_in = in_range(addr_q, BOARD_W, BOARD_H);
  assign hit     = shot_in && (fsm_cell == SHIP);
  // repeat shots on HIT/MISS cells leave the board alone
  assign we_shot = (state == S_UPDATE) && shot_in &&
                   ((fsm_cell == SHIP) ||
                    (fsm_cell == EMPTY));

  assign we      = place_ok || we_shot;
  assign wr_addr = place_ok ? place_addr : addr_q;
  assign wr_data = place_ok ? SHIP :
                   (hit ? HIT : MISS);

  shot_responder_board_mem u_board (
    .clk        (clk),
    .rst_n      (rst_n),
    .clear      (clear),
    .we         (we),
    .wr_addr    (wr_addr),
    .wr_data    (wr_data),
    .fsm_addr   (addr_q),
    .fsm_cell   (fsm_cell),
    .probe_addr (place_addr),
    .probe_cell (probe_cell),
    .disp_addr  (rd_addr),
    .disp_ok    (in_range(rd_addr, BOARD_W, BOARD_H)),
    .disp_cell  (disp_cell)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= S_IDLE;
      addr_q <= '0;
      left   <= '0;
      locked <= 1'b0;
      rdy    <= 1'b0;
      rv     <= 1'b0;
      msg    <= MSG_NONE;
    end else if (clear) begin
      state  <= S_IDLE;
      addr_q <= '0;
      left   <= '0;
      locked <= 1'b0;
      rdy    <= 1'b0;
      rv     <= 1'b0;
      msg    <= MSG_NONE;
    end else begin
      unique case (state)
        S_IDLE: begin
          if (shot_fire) begin
            addr_q <= sh.shot_addr;
            locked <= 1'b1;
            rdy    <= 1'b0;
            state  <= S_LOOKUP;
          end else begin
            if (place_ok)
              left <= left + 4'd1;
            rdy <= !sunk;
          end
        end
        S_LOOKUP: state <= S_UPDATE;
        S_UPDATE: begin
          if (hit) begin
            left <= left - 4'd1;
            msg  <= (left == 4'd1) ?
                    MSG_HIT_LAST : MSG_HIT;
          end else begin
            msg <= MSG_MISS;
          end
          state <= S_RESPOND;
        end
        S_RESPOND: begin
          // first RESPOND cycle raises valid, then wait for TX
          if (!rv) begin
            rv <= 1'b1;
          end else if (sh.resp_ready) begin
            rv    <= 1'b0;
            rdy   <= !sunk;
            state <= S_IDLE;
          end
        end
      endcase
    end
  end

  assign sh.shot_ready = rdy;
  assign sh.resp_valid = rv;
  assign sh.resp_msg   = msg;
  assign ships_left    = left;
  assign all_sunk      = sunk;
  assign rd_cell       = disp_cell;

endmodule
